// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel operand feeder for the pipelined 32-bit adder tree; collects a vector, waits out the tree latency, returns the sum.
// Optional early-end zero padding via `define ADDER_FEEDER_ZEROPAD_EN (adds the in_last port).
module adder_tree_feeder #(
    parameter int TREE_SIZE = 8,
    parameter int LATENCY   = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
`ifdef ADDER_FEEDER_ZEROPAD_EN
    input  logic                    in_last,
`endif
    output logic [32*TREE_SIZE-1:0] tree_in,
    input  logic [31:0]             tree_sum,
    output logic [31:0]             sum_data,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic                    busy
);

    localparam int IDX_W = (TREE_SIZE > 1) ? $clog2(TREE_SIZE) : 1;
    localparam int CNT_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {FILL, WAIT, HOLD} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             in_hs;
    logic             last_word;
    logic             pad_rest;

    assign in_hs = in_valid && in_ready;

    always_comb begin
        pad_rest = 1'b0;
`ifdef ADDER_FEEDER_ZEROPAD_EN
        pad_rest = in_last;
`endif
        last_word = (idx == IDX_W'(TREE_SIZE - 1)) || pad_rest;
    end

    // NOTE: the operand lanes are an ordinary register bank, so they take the async reset like any other state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            idx       <= '0;
            cnt       <= '0;
            tree_in   <= '0;
            sum_data  <= '0;
            sum_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_hs) begin
                        for (int k = 0; k < TREE_SIZE; k++) begin
                            if (IDX_W'(k) == idx)
                                tree_in[32*k +: 32] <= in_data;
                            else if (pad_rest && IDX_W'(k) > idx)
                                tree_in[32*k +: 32] <= '0;
                        end
                        busy <= 1'b1;
                        if (last_word) begin
                            idx      <= '0;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= WAIT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // tree_sum is valid LATENCY edges after tree_in settled; capture on the next one.
                    if (cnt == CNT_W'(LATENCY)) begin
                        sum_data  <= tree_sum;
                        sum_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Randomized self-checking bench for adder_tree_feeder with a behavioural registered adder-tree model.
module tb_adder_tree_feeder;

    localparam int TS  = 8;
    localparam int LAT = 3;
    localparam int W   = 32 * TS;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [W-1:0]  tree_in;
    logic [31:0]   tree_sum;
    logic [31:0]   sum_data;
    logic          sum_valid;
    logic          sum_ready;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] vec [TS];
    logic [31:0] pipe [LAT];

    always #5 clock = ~clock;

    adder_tree_feeder #(.TREE_SIZE(TS), .LATENCY(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef ADDER_FEEDER_ZEROPAD_EN
        .in_last   (in_last),
`endif
        .tree_in   (tree_in),
        .tree_sum  (tree_sum),
        .sum_data  (sum_data),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .busy      (busy)
    );

    // Registered tree model: the total of tree_in emerges LAT edges later.
    function automatic logic [31:0] tree_total(input logic [W-1:0] v);
        logic [31:0] s = '0;
        for (int k = 0; k < TS; k++) s += v[32*k +: 32];
        return s;
    endfunction

    always @(posedge clock) begin
        pipe[0] <= tree_total(tree_in);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign tree_sum = pipe[LAT-1];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Feeds vec[0..n-1], then follows the sum through WAIT and HOLD.
    task automatic run_vector(input string tag, input int n, input bit toggle,
                              input int stall, input bit use_last);
        int          sent = 0;
        int          cyc = 0;
        int          k = 0;
        bit          hs;
        bit          bad = 0;
        logic [31:0] exp_sum = '0;
        logic [31:0] held;
        logic [W-1:0] exp_tree = '0;

        for (int i = 0; i < n; i++) begin
            exp_sum += vec[i];
            exp_tree[32*i +: 32] = vec[i];
        end
        sum_ready = (stall == 0);
        while (sent < n && cyc < 400) begin
            if (toggle && (cyc % 2 == 1)) begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_data  = vec[sent];
                in_last  = use_last && (sent == n - 1);
            end
            hs = in_valid && in_ready;
            @(posedge clock); #1;
            if (hs) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        check({tag, "_accepted"}, W'(sent), W'(n));
        check({tag, "_tree_in"}, tree_in, exp_tree);
        check({tag, "_busy_fill"}, W'(busy), W'(1));

        while (!sum_valid && k < 50) begin
            if (in_ready) bad = 1;
            in_valid = $urandom_range(0, 1);
            @(posedge clock); #1;
            k++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, W'(k), W'(LAT + 1));
        check({tag, "_ready_wait"}, W'(bad), W'(0));
        check({tag, "_sum"}, W'(sum_data), W'(exp_sum));
        check({tag, "_busy_hold"}, W'(busy), W'(1));

        held = sum_data;
        bad  = 0;
        for (int s = 0; s < stall; s++) begin
            in_valid = $urandom_range(0, 1);
            in_data  = $urandom;
            @(posedge clock); #1;
            if (!sum_valid || sum_data !== held || in_ready || !busy) bad = 1;
        end
        in_valid = 1'b0;
        if (stall > 0) check({tag, "_hold_stable"}, W'(bad), W'(0));

        sum_ready = 1'b1;
        @(posedge clock); #1;
        check({tag, "_valid_drop"}, W'(sum_valid), W'(0));
        check({tag, "_ready_back"}, W'(in_ready), W'(1));
        check({tag, "_busy_idle"}, W'(busy), W'(0));
        check({tag, "_sum_after"}, W'(sum_data), W'(exp_sum));
        sum_ready = 1'b0;
    endtask

    initial begin
        bit seen;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        sum_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_tree_in", tree_in, '0);
        check("rst_sum_data", W'(sum_data), '0);
        check("rst_sum_valid", W'(sum_valid), '0);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_busy", W'(busy), '0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < TS; i++) vec[i] = 32'(i + 1);
        run_vector("t1_seq", TS, 1'b0, 0, 1'b0);

        for (int i = 0; i < TS; i++) vec[i] = 32'h2000_0000;
        run_vector("t2_wrap", TS, 1'b0, 0, 1'b0);

        for (int i = 0; i < TS; i++) vec[i] = 32'(i + 1);
        run_vector("t3_stall", TS, 1'b0, 5, 1'b0);

        // Abort a partial vector with reset.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(100 + i);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        check("t4_busy_partial", W'(busy), W'(1));
        reset = 1'b1;
        #2;
        check("t4_rst_tree_in", tree_in, '0);
        check("t4_rst_in_ready", W'(in_ready), W'(1));
        check("t4_rst_busy", W'(busy), '0);
        @(posedge clock); #3;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            if (sum_valid) seen = 1;
        end
        check("t4_no_sum", W'(seen), '0);
        for (int i = 0; i < TS; i++) vec[i] = 32'd2;
        run_vector("t4_after", TS, 1'b0, 0, 1'b0);

        for (int i = 0; i < TS; i++) vec[i] = 32'(10 * (i + 1));
        run_vector("t5_gaps", TS, 1'b1, 1, 1'b0);

`ifdef ADDER_FEEDER_ZEROPAD_EN
        vec[0] = 32'd5; vec[1] = 32'd6; vec[2] = 32'd7;
        run_vector("t6_pad", 3, 1'b0, 2, 1'b1);
        for (int i = 0; i < TS; i++) vec[i] = $urandom;
        run_vector("t6_last_full", TS, 1'b0, 0, 1'b1);
`endif

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < TS; i++) vec[i] = $urandom;
            run_vector($sformatf("rnd%0d", r), TS, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 6)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
